// File: rtl/isa_fifo_reader.sv
// Read-side controller for the 64-bit ISA instruction FIFO: pops words, hides the FIFO's
// 1-cycle read latency in a 2-entry skid buffer, and serves them on a valid/ready handshake.
module isa_fifo_reader #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [7:0]        instr_opcode,
  input  logic              flush,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned SUM_W = 3;
  localparam int unsigned OPC_W = 8;

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              deq;
  logic [SUM_W-1:0]  committed;

  assign instr_valid  = (occ_q != '0);
  assign instr_data   = head_q;
  assign instr_opcode = head_q[DATA_W-1 -: OPC_W];
  assign retired_cnt  = cnt_q;

  assign deq = instr_valid && instr_ready;

  // Slots already promised (buffered + returning) after this cycle's dequeue; deq implies occ >= 1.
  assign committed  = SUM_W'(occ_q) + SUM_W'(inflight_q) - SUM_W'(deq);
  assign fifo_rd_en = rst_n && !fifo_empty && !flush && (committed < SUM_W'(2));

  // Next-state: capture of the returning word, dequeue shift, flush and retire count
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd_en;
    cnt_d      = cnt_q;

    if (deq) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush) begin
      occ_d      = '0;
      inflight_d = 1'b0;
    end else begin
      case ({inflight_q, deq})
        2'b11: begin
          if (occ_q == OCC_W'(2)) begin
            head_d = tail_q;
            tail_d = fifo_dout;
          end else begin
            head_d = fifo_dout;
          end
        end
        2'b10: begin
          if (occ_q == '0) begin
            head_d = fifo_dout;
          end else begin
            tail_d = fifo_dout;
          end
          occ_d = occ_q + OCC_W'(1);
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - OCC_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
